hazard_stall_ctrl: RTL and testbench

- Hazard control unit for the 5-stage MIPS pipeline; produces the `stall` consumed by the ID/EX stall mux, plus PC/IF-ID write enables and stage flushes.
- Detects load-use hazards between ID and EX; holds multi-cycle load stalls with a counter; sequences control-flow flushes for taken branches (resolved in MEM) and jumps (resolved in ID).
- Registered FSM with Mealy outputs, so a hazard seen in cycle N stalls cycle N.

---
 rtl/hazard_stall_ctrl_if.sv | 49 ++++
 rtl/hazard_stall_ctrl.sv | 172 +++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_if
//   Bundle of pipeline-side signals exchanged with the hazard control unit.
//
//   Pipeline -> hazard unit (decode/execute/memory status):
//     id_valid, id_rs, id_rt, id_uses_rt   ID-stage instruction operands
//     ex_mem_read, ex_dst                  EX-stage load and its destination
//     id_jump                              jump decoded in ID
//     mem_branch_taken                     branch resolved taken in MEM
//   Hazard unit -> pipeline (control):
//     stall                                ID/EX stall mux select
//     pc_write, if_id_write                PC and IF/ID enables
//     flush_if_id, flush_id_ex, flush_ex_mem  stage clears
//
//   Modports: master = pipeline side, slave = hazard unit.
// ---------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
  parameter int unsigned REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_dst;
  logic              id_jump;
  logic              mem_branch_taken;

  logic              stall;
  logic              pc_write;
  logic              if_id_write;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              flush_ex_mem;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_dst,
           id_jump, mem_branch_taken,
    input  stall, pc_write, if_id_write, flush_if_id, flush_id_ex,
           flush_ex_mem
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_dst,
           id_jump, mem_branch_taken,
    output stall, pc_write, if_id_write, flush_if_id, flush_id_ex,
           flush_ex_mem
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//   Hazard control unit for a 5-stage MIPS pipeline. Detects load-use
//   hazards between ID and EX, holds multi-cycle load stalls with a small
//   down-counter, and sequences flushes for taken branches (resolved in MEM)
//   and jumps (resolved in ID). Outputs are Mealy: a hazard seen in a cycle
//   stalls that same cycle.
//
//   Parameters:
//     LOAD_STALL_CYCLES  bubbles per load-use hazard, legal range 1..7
//     REG_AW             register address width
//
//   Ports:
//     clk   pipeline clock, rising edge
//     rst   asynchronous active-high reset
//     bus   hazard_stall_ctrl_if.slave (pipeline status in, control out)
//
//   Optional feature (macro HAZARD_PERF_CNT_EN):
//     stall_count[31:0]  cycles with stall=1 outside reset (wraps)
//     flush_count[31:0]  cycles with mem_branch_taken=1 (wraps)
//     Both clear on rst. With the macro undefined these ports do not exist.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned REG_AW            = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_stall_ctrl_if.slave   bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          stall_count,
  output logic [31:0]          flush_count
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    LSTALL = 1'b1
  } state_t;

  // Counter value loaded on entry to LSTALL: the first bubble is produced
  // from IDLE, the remaining ones from LSTALL.
  localparam logic [2:0] CNT_INIT = 3'(LOAD_STALL_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        hz;
  logic        stall_o;
  logic        pc_write_o;
  logic        if_id_write_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        flush_ex_mem_o;

  // Load-use hazard: the load in EX writes a register the ID instruction
  // reads. $zero is never a real destination, so it never creates a hazard.
  always_comb begin
    hz = bus.id_valid && bus.ex_mem_read && (bus.ex_dst != '0) &&
         ((bus.ex_dst == bus.id_rs) ||
          (bus.id_uses_rt && (bus.ex_dst == bus.id_rt)));
  end

  // Next-state and Mealy outputs. Priority: taken branch, then load stall
  // (new hazard or ongoing LSTALL), then jump.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_o        = 1'b0;
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    flush_if_id_o  = 1'b0;
    flush_id_ex_o  = 1'b0;
    flush_ex_mem_o = 1'b0;

    if (rst) begin
      // Hold the front end frozen while reset is asserted.
      stall_o       = 1'b1;
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      state_d       = IDLE;
      cnt_d         = 3'd0;
    end else if (bus.mem_branch_taken) begin
      // Wrong-path instructions occupy IF/ID, ID/EX and EX/MEM; a branch
      // also aborts any load stall in progress.
      flush_if_id_o  = 1'b1;
      flush_id_ex_o  = 1'b1;
      flush_ex_mem_o = 1'b1;
      state_d        = IDLE;
      cnt_d          = 3'd0;
    end else if (state_q == LSTALL) begin
      // Keep inserting bubbles irrespective of hz; the load has already
      // been accounted for when the stall began.
      stall_o       = 1'b1;
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      if (cnt_q == 3'd1) begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end else if (hz) begin
      // A pending jump in ID is simply held; it is re-presented when the
      // stall releases IF/ID.
      stall_o       = 1'b1;
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d = LSTALL;
        cnt_d   = CNT_INIT;
      end
    end else if (bus.id_jump) begin
      // Only the sequentially fetched instruction in IF/ID is wrong-path.
      flush_if_id_o = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall        = stall_o;
  assign bus.pc_write     = pc_write_o;
  assign bus.if_id_write  = if_id_write_o;
  assign bus.flush_if_id  = flush_if_id_o;
  assign bus.flush_id_ex  = flush_id_ex_o;
  assign bus.flush_ex_mem = flush_ex_mem_o;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Counters wrap naturally at 2^32. The reset cycle itself is never
  // counted because the flops are held clear while rst is high.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall_o) begin
      stall_count_d = stall_count_q + 32'd1;
    end
    if (bus.mem_branch_taken) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Two instances (LOAD_STALL_CYCLES = 1 and 3) share the same stimulus.
//   A behavioural model tracks how many forced bubbles remain for each
//   instance and derives the expected control outputs every cycle; a few
//   directed sequences additionally pin hand-computed values.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus, driven with blocking assignments shortly after posedge.
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs = '0;
  logic [AW-1:0] id_rt = '0;
  logic          id_uses_rt = 1'b0;
  logic          ex_mem_read = 1'b0;
  logic [AW-1:0] ex_dst = '0;
  logic          id_jump = 1'b0;
  logic          mem_branch_taken = 1'b0;

  hazard_stall_ctrl_if #(.REG_AW(AW)) bus1 ();
  hazard_stall_ctrl_if #(.REG_AW(AW)) bus3 ();

  assign bus1.id_valid = id_valid;         assign bus3.id_valid = id_valid;
  assign bus1.id_rs = id_rs;               assign bus3.id_rs = id_rs;
  assign bus1.id_rt = id_rt;               assign bus3.id_rt = id_rt;
  assign bus1.id_uses_rt = id_uses_rt;     assign bus3.id_uses_rt = id_uses_rt;
  assign bus1.ex_mem_read = ex_mem_read;   assign bus3.ex_mem_read = ex_mem_read;
  assign bus1.ex_dst = ex_dst;             assign bus3.ex_dst = ex_dst;
  assign bus1.id_jump = id_jump;           assign bus3.id_jump = id_jump;
  assign bus1.mem_branch_taken = mem_branch_taken;
  assign bus3.mem_branch_taken = mem_branch_taken;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc1, fc1, sc3, fc3;
`endif

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .REG_AW(AW)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(sc1), .flush_count(fc1)
`endif
  );

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .REG_AW(AW)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(sc3), .flush_count(fc3)
`endif
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, wanted %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Output vector order: {stall, pc_write, if_id_write,
  //                       flush_if_id, flush_id_ex, flush_ex_mem}
  function automatic logic model_hz();
    return id_valid && ex_mem_read && (ex_dst != 0) &&
           ((ex_dst == id_rs) || (id_uses_rt && ex_dst == id_rt));
  endfunction

  function automatic logic [5:0] model_out(input int remaining, input logic h);
    if (rst)                     return 6'b100_000;
    if (mem_branch_taken)        return 6'b011_111;
    if (remaining > 0 || h)      return 6'b100_000;
    if (id_jump)                 return 6'b011_100;
    return 6'b011_000;
  endfunction

  // Bubbles still owed after the current cycle.
  function automatic int model_next(input int remaining, input logic h,
                                    input int stall_len);
    if (rst || mem_branch_taken) return 0;
    if (remaining > 0)           return remaining - 1;
    if (h)                       return stall_len - 1;
    return 0;
  endfunction

  int rem1 = 0;
  int rem3 = 0;
  logic [31:0] m_sc1 = 0, m_sc3 = 0, m_fc = 0;

  function automatic logic [5:0] outs1();
    return {bus1.stall, bus1.pc_write, bus1.if_id_write,
            bus1.flush_if_id, bus1.flush_id_ex, bus1.flush_ex_mem};
  endfunction

  function automatic logic [5:0] outs3();
    return {bus3.stall, bus3.pc_write, bus3.if_id_write,
            bus3.flush_if_id, bus3.flush_id_ex, bus3.flush_ex_mem};
  endfunction

  // Compare process: runs every cycle at the falling edge.
  always @(negedge clk) begin
    logic       h;
    logic [5:0] e1, e3;
    h  = model_hz();
    e1 = model_out(rem1, h);
    e3 = model_out(rem3, h);
    check("ctl_L1", {26'd0, outs1()}, {26'd0, e1});
    check("ctl_L3", {26'd0, outs3()}, {26'd0, e3});
`ifdef HAZARD_PERF_CNT_EN
    check("stall_count_L1", sc1, m_sc1);
    check("stall_count_L3", sc3, m_sc3);
    check("flush_count_L1", fc1, m_fc);
    check("flush_count_L3", fc3, m_fc);
`endif
    if (rst) begin
      m_sc1 = 0; m_sc3 = 0; m_fc = 0;
    end else begin
      if (e1[5]) m_sc1 = m_sc1 + 1;
      if (e3[5]) m_sc3 = m_sc3 + 1;
      if (mem_branch_taken) m_fc = m_fc + 1;
    end
    rem1 = model_next(rem1, h, 1);
    rem3 = model_next(rem3, h, 3);
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply(input logic v, input int rs, input int rt,
                       input logic ut, input logic mr, input int dst,
                       input logic j, input logic b);
    @(posedge clk);
    #1;
    id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt); id_uses_rt = ut;
    ex_mem_read = mr; ex_dst = AW'(dst); id_jump = j; mem_branch_taken = b;
  endtask

  task automatic idle();
    apply(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Let the cycle's compare run, then look at outputs for literal checks.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_stall", {31'd0, bus1.stall}, 32'd1);
    check("rst_pc_write", {31'd0, bus3.pc_write}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    settle();
    check("post_rst_stall", {31'd0, bus3.stall}, 32'd0);

    // lw $8 in EX, add using rs=8 in ID
    apply(1'b1, 8, 3, 1'b1, 1'b1, 8, 1'b0, 1'b0);
    settle();
    check("lu_L1_stall", {31'd0, bus1.stall}, 32'd1);
    check("lu_L1_pc_write", {31'd0, bus1.pc_write}, 32'd0);
    check("lu_L1_if_id_write", {31'd0, bus1.if_id_write}, 32'd0);
    apply(1'b1, 8, 3, 1'b1, 1'b0, 0, 1'b0, 1'b0);   // bubble now in EX
    settle();
    check("lu_L1_released", {31'd0, bus1.stall}, 32'd0);
    check("lu_L3_cycle2", {31'd0, bus3.stall}, 32'd1);
    idle();
    settle();
    check("lu_L3_cycle3", {31'd0, bus3.stall}, 32'd1);
    idle();
    settle();
    check("lu_L3_released", {31'd0, bus3.stall}, 32'd0);

    // $zero destination never stalls
    apply(1'b1, 0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    settle();
    check("zero_dst_L1", {31'd0, bus1.stall}, 32'd0);
    check("zero_dst_L3", {31'd0, bus3.stall}, 32'd0);

    // sw using rt=9 against lw $9: exactly three stall cycles on L3
    apply(1'b1, 4, 9, 1'b1, 1'b1, 9, 1'b0, 1'b0);
    settle();
    check("sw_rt_s1", {31'd0, bus3.stall}, 32'd1);
    apply(1'b1, 4, 9, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    settle();
    check("sw_rt_s2", {31'd0, bus3.stall}, 32'd1);
    idle();
    settle();
    check("sw_rt_s3", {31'd0, bus3.stall}, 32'd1);
    idle();
    settle();
    check("sw_rt_done", {31'd0, bus3.stall}, 32'd0);

    // Branch taken in second stall cycle aborts the load stall
    apply(1'b1, 7, 0, 1'b0, 1'b1, 7, 1'b0, 1'b0);
    settle();
    check("br_abort_s1", {31'd0, bus3.stall}, 32'd1);
    apply(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    settle();
    check("br_abort_flushes",
          {29'd0, bus3.flush_if_id, bus3.flush_id_ex, bus3.flush_ex_mem}, 32'd7);
    check("br_abort_stall", {31'd0, bus3.stall}, 32'd0);
    idle();
    settle();
    check("br_abort_after", {31'd0, bus3.stall}, 32'd0);

    // Jump coinciding with a hazard: stall wins, jump flushes next cycle
    apply(1'b1, 6, 0, 1'b0, 1'b1, 6, 1'b1, 1'b0);
    settle();
    check("jmp_hz_stall", {31'd0, bus1.stall}, 32'd1);
    check("jmp_hz_no_flush", {31'd0, bus1.flush_if_id}, 32'd0);
    apply(1'b1, 6, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    settle();
    check("jmp_flush", {31'd0, bus1.flush_if_id}, 32'd1);
    check("jmp_pc_write", {31'd0, bus1.pc_write}, 32'd1);
    idle();
    idle();
    idle();

    // Reset in the middle of an L3 stall (counter at 2)
    apply(1'b1, 5, 0, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    settle();
    check("rst_mid_s1", {31'd0, bus3.stall}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    id_valid = 1'b0; ex_mem_read = 1'b0;
    #1;
    check("rst_mid_stall", {31'd0, bus3.stall}, 32'd1);
    check("rst_mid_pc_write", {31'd0, bus3.pc_write}, 32'd0);
    settle();
    @(posedge clk);
    #1 rst = 1'b0;
    settle();
    check("rst_mid_released", {31'd0, bus3.stall}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("rst_mid_sc", sc3, 32'd0);
    check("rst_mid_fc", fc3, 32'd0);
`endif

    // Randomized traffic with a narrow register space to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst              = ($urandom_range(0, 199) == 0);
      id_valid         = ($urandom_range(0, 3) != 0);
      id_rs            = AW'($urandom_range(0, 3));
      id_rt            = AW'($urandom_range(0, 3));
      id_uses_rt       = 1'($urandom_range(0, 1));
      ex_mem_read      = 1'($urandom_range(0, 1));
      ex_dst           = AW'($urandom_range(0, 3));
      id_jump          = ($urandom_range(0, 3) == 0);
      mem_branch_taken = ($urandom_range(0, 9) == 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
